// File: rtl/bnn_param_loader.sv
// -----------------------------------------------------------------------------
// bnn_param_loader
//
// Streams a configuration byte stream into a daisy-chained row of neurons.
// Each accepted byte is shifted MSB-first onto the chain, one bit per clock,
// with `setup` high only for the clocks that actually move a bit. The bits
// falling off the end of the chain (the previous configuration) are packed
// back into bytes for readback.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle request to begin a full chain load
//   in_data/in_valid      configuration byte and its valid
//   in_ready              byte accepted this cycle (decode of WAIT_BYTE)
//   chain_in              param_out of the last neuron in the chain
//   setup                 shift-enable to every neuron
//   param_out             serial data into the first neuron
//   busy                  load in progress
//   done                  chain holds a complete new configuration
//   rd_data/rd_valid      readback byte of the previous chain contents
// -----------------------------------------------------------------------------
module bnn_param_loader #(
   parameter int NEURONS   = 8,
   parameter int INPUTS    = 8,
   parameter int BIAS_BITS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       chain_in,
   output logic       setup,
   output logic       param_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid
);

   localparam int TOTAL_BITS = NEURONS * (INPUTS + BIAS_BITS);
   localparam int BL_W       = $clog2(TOTAL_BITS + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BYTE = 2'd1,
      SHIFT     = 2'd2,
      DONE      = 2'd3
   } state_e;

   state_e          state_q,     state_d;
   logic [BL_W-1:0] bits_left_q, bits_left_d;
   logic [2:0]      bit_idx_q,   bit_idx_d;
   logic [7:0]      shreg_q,     shreg_d;
   logic [6:0]      rd_shift_q,  rd_shift_d;
   logic [2:0]      rd_cnt_q,    rd_cnt_d;
   logic [7:0]      rd_data_q,   rd_data_d;
   logic            rd_valid_q,  rd_valid_d;
   logic            busy_q,      busy_d;
   logic            done_q,      done_d;

   // Readback byte as it would look with this cycle's exiting bit appended.
   logic [7:0]      rd_word;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      state_d     = state_q;
      bits_left_d = bits_left_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      rd_shift_d  = rd_shift_q;
      rd_cnt_d    = rd_cnt_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      rd_word     = {rd_shift_q, chain_in};

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = WAIT_BYTE;
               bits_left_d = BL_W'(TOTAL_BITS);
               rd_shift_d  = '0;
               rd_cnt_d    = '0;
            end
         end

         WAIT_BYTE: begin
            // start is deliberately not looked at here: a load in progress
            // cannot be restarted except by reset.
            if (in_valid) begin
               shreg_d   = in_data;
               bit_idx_d = '0;
               state_d   = SHIFT;
            end
         end

         SHIFT: begin
            shreg_d     = {shreg_q[6:0], 1'b0};
            bits_left_d = bits_left_q - BL_W'(1);
            bit_idx_d   = bit_idx_q + 3'd1;
            rd_shift_d  = rd_word[6:0];
            rd_cnt_d    = rd_cnt_q + 3'd1;

            if (rd_cnt_q == 3'd7) begin
               rd_data_d  = rd_word;
               rd_valid_d = 1'b1;
            end

            if (bits_left_q == BL_W'(1)) begin
               state_d = DONE;
               // Partial last readback byte: left-align, stale upper bits of
               // rd_word fall off the top and zeros fill from the bottom.
               if (rd_cnt_q != 3'd7) begin
                  rd_data_d  = rd_word << (3'd7 - rd_cnt_q);
                  rd_valid_d = 1'b1;
               end
            end else if (bit_idx_q == 3'd7) begin
               state_d = WAIT_BYTE;
            end
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d == WAIT_BYTE) || (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bits_left_q <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         rd_shift_q  <= '0;
         rd_cnt_q    <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bits_left_q <= bits_left_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         rd_shift_q  <= rd_shift_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // setup/param_out decode the registered state so they fall the instant
   // reset asserts; the chain then freezes with whatever it already holds.
   assign setup     = (state_q == SHIFT);
   assign param_out = setup & shreg_q[7];
   assign in_ready  = (state_q == WAIT_BYTE);
   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;

endmodule

// File: doc/bnn_param_loader.md
# bnn_param_loader

Sequencer that loads weights and biases into a daisy-chained row of `neuron` instances. A byte stream arrives over a valid/ready handshake. The loader serialises it MSB-first onto the chain's `param_in` and gates the chain's `setup` line for exactly one clock per bit. It also captures the previous configuration as it leaves the end of the chain and returns it as bytes for readback. It sits between the host/IO shim and the neuron array, and signals when the array holds a complete configuration and may be used for inference.

## Interface
- `NEURONS`, 8, number of neurons in the chain.
- `INPUTS`, 8, weight bits per neuron; must match the neuron instances.
- `BIAS_BITS`, 3, bias bits per neuron; must match the neuron instances.
- `TOTAL_BITS` (localparam), NEURONS*(INPUTS+BIAS_BITS); chain length in bits.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a full chain load.
- `in_data`  in  8  configuration byte, MSB shifted first.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `chain_in`  in  1  `param_out` of the last neuron in the chain.
- `setup`  out  1  drives every neuron's `setup`; high = shift one bit this clock.
- `param_out`  out  1  drives the first neuron's `param_in`.
- `busy`  out  1  load in progress.
- `done`  out  1  chain holds a complete new configuration.
- `rd_data`  out  8  readback byte of the previous chain contents.
- `rd_valid`  out  1  one-cycle strobe that qualifies `rd_data`.

## Operation
- **States:** IDLE, WAIT_BYTE, SHIFT, DONE.
- **Counters:**
  - `bits_left`: width $clog2(TOTAL_BITS+1), loaded with TOTAL_BITS on start.
  - `bit_idx`: 0..7 within the current byte.
  - `rd_cnt`: 0..7 readback bits captured.
- **IDLE / DONE + `start`:**
  - Go to WAIT_BYTE.
  - `done` clears.
  - `bits_left` = TOTAL_BITS.
  - The readback shifter clears.
- **`start` while busy:** ignored while in WAIT_BYTE or SHIFT.
- **WAIT_BYTE:**
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`, latch `in_data` into the shift register, set `bit_idx` = 0, and go to SHIFT.
- **SHIFT, each cycle:**
  - `setup` = 1 and `param_out` = current MSB of the shift register.
  - Sample `chain_in` into the readback shifter at its LSB. This is the bit leaving the chain this cycle.
  - Shift the byte register left.
  - Decrement `bits_left` and increment `bit_idx`.
- **Leaving SHIFT:**
  - When `bits_left` reaches 0, go to DONE.
  - Otherwise, when `bit_idx` reaches 8, go to WAIT_BYTE.
- **Final byte:** when TOTAL_BITS is not a multiple of 8, only the upper TOTAL_BITS%8 bits of the last byte are shifted. Its remaining bits are discarded.
- **Readback:** `rd_valid` pulses when 8 bits have been captured. On the final shift, a partial readback byte is flushed left-aligned with zero padding and `rd_valid` pulses.
- **Stream order:** the first bit sent ends deepest in the chain. Per neuron, last neuron first, send bias[BIAS_BITS-1..0] then weights[INPUTS-1..0].
- **DONE:** `done` = 1 and held until the next `start`. `setup` = 0 and `busy` = 0.
- **Outside SHIFT:** `setup` is never high, so neurons hold their parameters.

## Timing
- **Reset values:**
  - State = IDLE.
  - `setup`, `param_out`, `in_ready`, `busy`, `done`, `rd_valid` = 0.
  - `rd_data` = 0.
- **Outputs are registered except `in_ready`.**
  - `in_ready` is a decode of state == WAIT_BYTE.
  - `setup` and `param_out` are state-qualified so they drop combinationally on reset.
- **`start` to `in_ready`:** `start` sampled at edge N gives `in_ready` = 1 during cycle N+1.
- **Byte to shift:** a byte accepted at edge N is shifted on edges N+1..N+8, one bit per edge, with `setup` high across those cycles.
- **Back-to-back bytes:** the next accept is possible one cycle after the last shift. Throughput is 9 cycles per byte.
- **`busy`:** high from the cycle after `start` through the last SHIFT cycle.
- **`done`:** rises the cycle after the last shift.
- **`rd_valid`:** rises the cycle after the 8th captured bit, or after the final shift for the partial flush.
- **Stalls:** `in_valid` low in WAIT_BYTE stalls indefinitely. `setup` stays low, so the chain is partially loaded but stable.
- **Reset mid-load:**
  - `setup` drops immediately.
  - The chain keeps whatever bits were shifted.
  - `done` = 0; host must restart the load.
- **Simultaneous `start` and `in_valid` in IDLE:** the byte is not accepted (`in_ready` = 0 that cycle).

## Test plan
- **Reset:** NEURONS=1, assert `rst_n`=0 mid-run → all outputs 0, state IDLE, no `setup` pulses.
- **Single-neuron load:** NEURONS=1 (11 bits), `start`, bytes 0xB5, 0x60 → exactly 11 `setup` cycles.
  - `param_out` sequence is 1,0,1,1,0,1,0,1,0,1,1.
  - Neuron ends with bias=3'b101 and weights=8'b10101011.
  - `done`=1 one cycle after the 11th shift.
- **Multi-neuron load with partial last byte:** NEURONS=3 (33 bits), 5 bytes → 33 `setup` cycles.
  - The 5th byte contributes only its MSB.
  - Each neuron's weights and bias match the stream order.
  - `in_ready` stays 0 after the 5th accept.
- **Readback:** load pattern A, then load pattern B.
  - `rd_data` bytes during load B equal pattern A in send order.
  - 5 `rd_valid` strobes; the last is 8'b?0000000 with the captured bit in the MSB.
- **Stall and ignored start:** hold `in_valid`=0 for 20 cycles mid-load and pulse `start` meanwhile.
  - No `setup` pulses during the stall.
  - `start` is ignored and `bits_left` is unchanged.
  - The load completes normally after `in_valid` resumes.
- **Reset during SHIFT:** assert `rst_n`=0 on the 4th shift of byte 2.
  - `setup` falls in the same cycle.
  - `done`=0.
  - A following full load completes correctly.
